// File: rtl/gw_image_pkg.sv
// Shared constants and types for the background/mask image store in SDRAM.
// The CLEAR writer state exists only when IMG_WRITER_CLEAR_EN is defined.
package gw_image_pkg;

  localparam int unsigned IMAGE_W         = 720;
  localparam int unsigned IMAGE_H         = 720;
  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned IMAGE_BYTES     = IMAGE_W * IMAGE_H * BYTES_PER_PIXEL;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned IDX_W  = 26;

  typedef enum logic {
    PLANE_BG   = 1'b0,
    PLANE_MASK = 1'b1
  } plane_e;

`ifdef IMG_WRITER_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_CLEAR  = 2'd3
  } writer_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } writer_state_e;
`endif

  localparam logic [1:0] BE_BG   = 2'b01;
  localparam logic [1:0] BE_MASK = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    plane_e            plane;
  } wr_entry_t;

  function automatic logic [1:0] plane_be(input plane_e plane);
    return (plane == PLANE_MASK) ? BE_MASK : BE_BG;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/image_sdram_writer.sv
// Write side of the interleaved background/mask image store: planar byte streams in, byte-lane SDRAM writes out.
// Defining IMG_WRITER_CLEAR_EN adds a CLEAR state that zeroes the whole region.
module image_sdram_writer #(
  parameter logic [24:0] BASE_WORD   = 25'h0,
  parameter int unsigned IMAGE_BYTES = gw_image_pkg::IMAGE_BYTES,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_plane,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  input  logic        clear_start,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_data,
  output logic [1:0]  sd_byte_en,
  output logic        sd_wr_req,
  input  logic        sd_wr_ack,
  output logic        busy,
  output logic        done,
  output logic        dl_error
);
  import gw_image_pkg::*;

  localparam int unsigned      PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(IMAGE_BYTES);

  writer_state_e    state;
  writer_state_e    state_next;
  logic             active_q;
  logic             rise;
  logic             start;
  logic             accept;
  plane_e           plane_q;
  plane_e           cur_plane;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;
  logic             in_range;
  logic             push;
  logic             pop;
  wr_entry_t        push_entry;
  wr_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_count_unused;
  logic             in_clear;
  logic             clear_load;
  logic [24:0]      clear_addr;

  assign rise = dl_active && !active_q;
  assign busy = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_STREAM;
          start      = 1'b1;
          accept     = dl_wr;
`ifdef IMG_WRITER_CLEAR_EN
        end else if (clear_start) begin
          state_next = ST_CLEAR;
`endif
        end
      end
      ST_STREAM: begin
        accept = dl_wr;
        if (!dl_active) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
`ifdef IMG_WRITER_CLEAR_EN
      ST_CLEAR: begin
        if (!clear_load && !sd_wr_req) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // The rise cycle itself carries byte 0, before idx/plane_q have been loaded.
  assign cur_idx    = start ? '0 : idx;
  assign cur_plane  = start ? plane_e'(dl_plane) : plane_q;
  assign in_range   = (cur_idx < LIMIT);
  assign push       = accept && in_range && !fifo_full;
  assign push_entry = '{addr: BASE_WORD + cur_idx[ADDR_W-1:0], data: dl_data, plane: cur_plane};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      active_q <= 1'b0;
      plane_q  <= PLANE_BG;
      idx      <= '0;
      dl_error <= 1'b0;
    end else begin
      state    <= state_next;
      active_q <= dl_active;
      if (start) plane_q <= plane_e'(dl_plane);

      // Dropped bytes still consume an index; the counter saturates rather than wraps.
      if (accept)     idx <= (cur_idx == '1) ? cur_idx : cur_idx + 1'b1;
      else if (start) idx <= '0;

      if (accept && !push)     dl_error <= 1'b1;
      else if (in_clear && rise) dl_error <= 1'b1;
      else if (start)          dl_error <= 1'b0;
    end
  end

  assign pop = sd_wr_req && sd_wr_ack && !in_clear;

  sync_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

`ifdef IMG_WRITER_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt;

  assign in_clear   = (state == ST_CLEAR);
  assign clear_load = in_clear && (clr_cnt < LIMIT);
  assign clear_addr = BASE_WORD + clr_cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (state == ST_IDLE) begin
      clr_cnt <= '0;
    end else if (in_clear && sd_wr_req && sd_wr_ack) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign in_clear           = 1'b0;
  assign clear_load         = 1'b0;
  assign clear_addr         = BASE_WORD;
`endif

  // The presented write stays in the FIFO until acked, so it counts toward full.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_wr_req  <= 1'b0;
      sd_addr    <= '0;
      sd_data    <= '0;
      sd_byte_en <= '0;
    end else if (sd_wr_req) begin
      if (sd_wr_ack) sd_wr_req <= 1'b0;
    end else if (clear_load) begin
      sd_wr_req  <= 1'b1;
      sd_addr    <= clear_addr;
      sd_data    <= '0;
      sd_byte_en <= BE_ALL;
    end else if (!fifo_empty) begin
      sd_wr_req  <= 1'b1;
      sd_addr    <= head.addr;
      sd_data    <= {head.data, head.data};
      sd_byte_en <= plane_be(head.plane);
    end
  end

endmodule

// File: tb/tb_image_sdram_writer.sv
// Directed bench for image_sdram_writer: a full-size instance and a 4-byte instance share the loader inputs.
// With IMG_WRITER_CLEAR_EN defined a third 8-byte instance exercises the region clear.
module tb_image_sdram_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dl_active;
  logic       dl_plane;
  logic       dl_wr;
  logic [7:0] dl_data;
  logic       clear_start;
  logic       ack;
  int         sel;
  int         n_tests;
  int         n_fail;

  logic [24:0] a_addr, b_addr, m_addr;
  logic [15:0] a_data, b_data, m_data;
  logic [1:0]  a_be, b_be, m_be;
  logic        a_req, b_req, m_req;
  logic        a_busy, b_busy, m_busy;
  logic        a_done, b_done, m_done;
  logic        a_err, b_err, m_err;
  logic        a_ack, b_ack;

  assign a_ack = ack && (sel == 0);
  assign b_ack = ack && (sel == 1);

  image_sdram_writer #(.BASE_WORD(25'h0), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_plane(dl_plane), .dl_wr(dl_wr),
    .dl_data(dl_data), .clear_start(clear_start), .sd_addr(a_addr), .sd_data(a_data),
    .sd_byte_en(a_be), .sd_wr_req(a_req), .sd_wr_ack(a_ack), .busy(a_busy), .done(a_done),
    .dl_error(a_err)
  );

  image_sdram_writer #(.BASE_WORD(25'h1000), .IMAGE_BYTES(4), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_plane(dl_plane), .dl_wr(dl_wr),
    .dl_data(dl_data), .clear_start(clear_start), .sd_addr(b_addr), .sd_data(b_data),
    .sd_byte_en(b_be), .sd_wr_req(b_req), .sd_wr_ack(b_ack), .busy(b_busy), .done(b_done),
    .dl_error(b_err)
  );

`ifdef IMG_WRITER_CLEAR_EN
  logic [24:0] c_addr;
  logic [15:0] c_data;
  logic [1:0]  c_be;
  logic        c_req, c_busy, c_done, c_err, c_ack;

  assign c_ack = ack && (sel == 2);

  image_sdram_writer #(.BASE_WORD(25'h0), .IMAGE_BYTES(8), .FIFO_DEPTH(16)) dut_c (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_plane(dl_plane), .dl_wr(dl_wr),
    .dl_data(dl_data), .clear_start(clear_start), .sd_addr(c_addr), .sd_data(c_data),
    .sd_byte_en(c_be), .sd_wr_req(c_req), .sd_wr_ack(c_ack), .busy(c_busy), .done(c_done),
    .dl_error(c_err)
  );
`endif

  // Route the selected instance onto the m_* observation signals.
  always_comb begin
    m_addr = a_addr; m_data = a_data; m_be = a_be; m_req = a_req;
    m_busy = a_busy; m_done = a_done; m_err = a_err;
    if (sel == 1) begin
      m_addr = b_addr; m_data = b_data; m_be = b_be; m_req = b_req;
      m_busy = b_busy; m_done = b_done; m_err = b_err;
    end
`ifdef IMG_WRITER_CLEAR_EN
    if (sel == 2) begin
      m_addr = c_addr; m_data = c_data; m_be = c_be; m_req = c_req;
      m_busy = c_busy; m_done = c_done; m_err = c_err;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for a request, checks it, and acks it in the cycle it is seen.
  task automatic expect_write(input logic [24:0] addr, input logic [15:0] data,
                              input logic [1:0] be, input string tag);
    int w;
    w = 0;
    while (!m_req && w < 200) begin
      tick();
      w++;
    end
    check($sformatf("%s[%0h] req", tag, addr), 32'(m_req), 32'(1));
    if (m_req) begin
      check($sformatf("%s[%0h] addr", tag, addr), 32'(m_addr), 32'(addr));
      check($sformatf("%s[%0h] data", tag, addr), 32'(m_data), 32'(data));
      check($sformatf("%s[%0h] be", tag, addr), 32'(m_be), 32'(be));
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_active = 1'b0; dl_wr = 1'b0; dl_plane = 1'b0; dl_data = 8'h00;
    clear_start = 1'b0; ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; sel = 0;
    reset = 1'b1; ack = 1'b0; clear_start = 1'b0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_plane = 1'b0; dl_data = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst req", 32'(a_req), 32'(0));
    check("rst busy", 32'(a_busy), 32'(0));
    check("rst done", 32'(a_done), 32'(0));
    check("rst err", 32'(a_err), 32'(0));
    check("rst addr", 32'(a_addr), 32'(0));
    check("rst data", 32'(a_data), 32'(0));
    check("rst be", 32'(a_be), 32'(0));
    reset = 1'b0;
    tick();

    // Background plane, 6 bytes, acked as soon as each request appears
    fork
      begin
        dl_active = 1'b1; dl_plane = 1'b0;
        for (int i = 0; i < 6; i++) begin
          dl_wr = 1'b1; dl_data = 8'(i + 1);
          tick();
        end
        dl_wr = 1'b0; dl_active = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] b;
          b = 8'(i + 1);
          expect_write(25'(i), {b, b}, 2'b01, "bg");
        end
      end
    join
    check("bg done", 32'(m_done), 32'(1));
    tick();
    check("bg done pulse", 32'(m_done), 32'(0));
    check("bg idle", 32'(m_busy), 32'(0));
    check("bg err", 32'(m_err), 32'(0));

    // Mask plane, 3 bytes, ack withheld for 40 cycles
    dl_active = 1'b1; dl_plane = 1'b1;
    dl_wr = 1'b1; dl_data = 8'hAA; tick();
    dl_data = 8'hBB; tick();
    dl_data = 8'hCC; tick();
    dl_wr = 1'b0; dl_active = 1'b0;
    repeat (40) tick();
    check("mask held req", 32'(m_req), 32'(1));
    check("mask held addr", 32'(m_addr), 32'(0));
    check("mask held busy", 32'(m_busy), 32'(1));
    check("mask held done", 32'(m_done), 32'(0));
    expect_write(25'd0, 16'hAAAA, 2'b10, "mask");
    check("mask early done", 32'(m_done), 32'(0));
    expect_write(25'd1, 16'hBBBB, 2'b10, "mask");
    expect_write(25'd2, 16'hCCCC, 2'b10, "mask");
    check("mask done", 32'(m_done), 32'(1));
    check("mask err", 32'(m_err), 32'(0));
    tick();

    // 20 back-to-back bytes, no ack: 16 fit, 4 dropped
    dl_active = 1'b1; dl_plane = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dl_wr = 1'b1; dl_data = 8'(8'h40 + i);
      tick();
    end
    dl_wr = 1'b0; dl_active = 1'b0;
    tick();
    check("ovf err", 32'(m_err), 32'(1));
    check("ovf idx", 32'(dut_a.idx), 32'd20);
    check("ovf req", 32'(m_req), 32'(1));
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(8'h40 + i);
      expect_write(25'(i), {b, b}, 2'b01, "ovf");
    end
    check("ovf done", 32'(m_done), 32'(1));
    tick();
    check("ovf no extra req", 32'(m_req), 32'(0));
    check("ovf err sticky", 32'(m_err), 32'(1));

    // Empty plane start clears the sticky error and drains at once
    dl_active = 1'b1; dl_plane = 1'b0;
    tick();
    check("restart err clr", 32'(m_err), 32'(0));
    check("restart busy", 32'(m_busy), 32'(1));
    dl_active = 1'b0;
    tick();
    check("empty plane done", 32'(m_done), 32'(1));
    tick();
    check("empty plane idle", 32'(m_busy), 32'(0));

    // 4-byte region: 6 bytes in, 4 written, error on the 5th
    do_reset();
    sel = 1;
    dl_active = 1'b1; dl_plane = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1; dl_data = 8'(8'h10 + i);
      tick();
      if (i == 3) check("range err after 4", 32'(m_err), 32'(0));
      if (i == 4) check("range err on 5th", 32'(m_err), 32'(1));
    end
    dl_wr = 1'b0; dl_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      expect_write(25'h1000 + 25'(i), {b, b}, 2'b01, "range");
    end
    check("range done", 32'(m_done), 32'(1));
    tick();
    check("range no 5th req", 32'(m_req), 32'(0));
    check("range err sticky", 32'(m_err), 32'(1));

    // Reset mid-transfer with 5 entries queued in A (B also has its error set)
    do_reset();
    sel = 0;
    dl_active = 1'b1; dl_plane = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dl_wr = 1'b1; dl_data = 8'(8'h70 + i);
      tick();
    end
    dl_wr = 1'b0;
    check("pre-rst req", 32'(a_req), 32'(1));
    check("pre-rst b err", 32'(b_err), 32'(1));
    reset = 1'b1; dl_active = 1'b0;
    tick();
    check("mid-rst req", 32'(a_req), 32'(0));
    check("mid-rst busy", 32'(a_busy), 32'(0));
    check("mid-rst done", 32'(a_done), 32'(0));
    check("mid-rst err", 32'(a_err), 32'(0));
    check("mid-rst b err", 32'(b_err), 32'(0));
    reset = 1'b0;
    repeat (3) tick();
    check("post-rst abandoned", 32'(a_req), 32'(0));

`ifdef IMG_WRITER_CLEAR_EN
    // Region clear on the 8-byte instance
    do_reset();
    sel = 2;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr busy", 32'(m_busy), 32'(1));
    for (int i = 0; i < 8; i++) begin
      expect_write(25'(i), 16'h0000, 2'b11, "clr");
      if (i == 1) begin
        dl_active = 1'b1;
        tick();
        dl_active = 1'b0;
        check("clr rise err", 32'(m_err), 32'(1));
      end
      if (i < 7) check("clr early done", 32'(m_done), 32'(0));
    end
    check("clr done", 32'(m_done), 32'(1));
    tick();
    check("clr done pulse", 32'(m_done), 32'(0));
    check("clr idle", 32'(m_busy), 32'(0));
`else
    // clear_start has no effect when the clear feature is not built
    do_reset();
    sel = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr ignored busy", 32'(m_busy), 32'(0));
    tick();
    check("clr ignored req", 32'(m_req), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
